// File: rtl/segasys1_romload_ctrl_if.sv
// ----------------------------------------------------------------------------
// segasys1_romload_ctrl_if
// Shared ROM write port between the download sequencer and the System 1
// main/sound/video ROM write ports.
//   wr_sel  [3:0]  one-hot region select (0 when wr_stb=0)
//   wr_addr [15:0] region-local byte address
//   wr_data [7:0]  write data
//   wr_stb         write valid
//   wr_rdy         target accepts; transfer on wr_stb & wr_rdy
// master: the sequencer drives the write, slave: the ROM side returns wr_rdy.
// ----------------------------------------------------------------------------
interface segasys1_romload_ctrl_if;
  logic [3:0]  wr_sel;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_stb;
  logic        wr_rdy;

  modport master (output wr_sel, output wr_addr, output wr_data, output wr_stb,
                  input  wr_rdy);
  modport slave  (input  wr_sel, input  wr_addr, input  wr_data, input  wr_stb,
                  output wr_rdy);
endinterface

// File: rtl/segasys1_romload_ctrl.sv
// ----------------------------------------------------------------------------
// segasys1_romload_ctrl
// Sequences the ROM download stream into the System 1 memories. Each strobed
// byte is decoded to one of four regions (main CPU, sound CPU, tiles,
// sprites), buffered in a 4-entry FIFO and issued on one shared write port.
// The game system is held in reset until the image is written plus a settle
// delay of HOLD_CYC cycles.
// Ports:
//   clk48M, reset     clock, synchronous active-high reset
//   dl_act            download session active
//   ROMEN/ROMAD/ROMDT byte strobe, image address, byte data
//   wr                write port (master side of segasys1_romload_ctrl_if)
//   sys_reset         reset to CPUs and video, low only in RUN
//   dl_done           image written and hold expired (survives reset)
//   dl_ovf            sticky: a byte was dropped on FIFO full
//   byte_cnt          strobes seen in the current session (saturating)
// ----------------------------------------------------------------------------
module segasys1_romload_ctrl #(
  parameter logic [24:0] R0_END   = 25'h000C000,
  parameter logic [24:0] R1_END   = 25'h000E000,
  parameter logic [24:0] R2_END   = 25'h001A000,
  parameter logic [24:0] R3_END   = 25'h002A000,
  parameter logic [7:0]  HOLD_CYC = 8'd16
) (
  input  logic                           clk48M,
  input  logic                           reset,
  input  logic                           dl_act,
  input  logic                           ROMEN,
  input  logic [24:0]                    ROMAD,
  input  logic [7:0]                     ROMDT,
  segasys1_romload_ctrl_if.master        wr,
  output logic                           sys_reset,
  output logic                           dl_done,
  output logic                           dl_ovf,
  output logic [24:0]                    byte_cnt
);

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4
  } state_t;

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] addr;
    logic [7:0]  data;
  } entry_t;

  localparam logic [24:0] CNT_MAX = {25{1'b1}};

  state_t      state_r, state_nxt_s;
  logic [7:0]  hold_cnt_r, hold_cnt_nxt_s;
  entry_t      mem_r     [4];
  entry_t      mem_nxt_s [4];
  logic [1:0]  rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s;
  logic [2:0]  count_r, count_nxt_s;
  entry_t      in_s, head_nxt_s;
  logic        accept_s, push_req_s, push_s, pop_s, drop_s, full_s;
  logic        enter_load_s;
  logic        wr_stb_r;
  logic [3:0]  wr_sel_r;
  logic [15:0] wr_addr_r;
  logic [7:0]  wr_data_r;
  logic        sys_reset_r;
  logic        dl_ovf_r, dl_ovf_nxt_s;
  logic [24:0] byte_cnt_r, byte_cnt_nxt_s;
  // dl_done survives reset so a user reset can skip the download; power-up 0.
  logic        dl_done_r = 1'b0;

  // Region decode: sel=0 means the byte lies above the sprite ROM.
  function automatic entry_t decode(input logic [24:0] ad, input logic [7:0] dt);
    entry_t      e;
    logic [24:0] off;
    if (ad < R0_END) begin
      e.sel = 4'b0001; off = ad;
    end else if (ad < R1_END) begin
      e.sel = 4'b0010; off = ad - R0_END;
    end else if (ad < R2_END) begin
      e.sel = 4'b0100; off = ad - R1_END;
    end else if (ad < R3_END) begin
      e.sel = 4'b1000; off = ad - R2_END;
    end else begin
      e.sel = 4'b0000; off = 25'd0;
    end
    e.addr = off[15:0];
    e.data = dt;
    return e;
  endfunction

  // FIFO next state; the write port registers are loaded from the next head
  // so a byte strobed into an empty FIFO is presented on the following cycle.
  always_comb begin
    in_s         = decode(ROMAD, ROMDT);
    accept_s     = (state_r == LOAD) && ROMEN;
    push_req_s   = accept_s && (in_s.sel != 4'b0000);
    pop_s        = wr_stb_r && wr.wr_rdy;
    full_s       = (count_r == 3'd4);
    push_s       = push_req_s && (!full_s || pop_s);
    drop_s       = push_req_s && full_s && !pop_s;
    mem_nxt_s    = mem_r;
    if (push_s) begin
      mem_nxt_s[wr_ptr_r] = in_s;
    end else begin
      mem_nxt_s[wr_ptr_r] = mem_r[wr_ptr_r];
    end
    wr_ptr_nxt_s = wr_ptr_r + {1'b0, push_s};
    rd_ptr_nxt_s = rd_ptr_r + {1'b0, pop_s};
    count_nxt_s  = count_r + {2'b00, push_s} - {2'b00, pop_s};
    head_nxt_s   = mem_nxt_s[rd_ptr_nxt_s];
  end

  // Session FSM next state and hold counter.
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    case (state_r)
      BOOT: begin
        if (dl_act) begin
          state_nxt_s = LOAD;
        end else if (dl_done_r) begin
          state_nxt_s    = HOLD;
          hold_cnt_nxt_s = HOLD_CYC;
        end else begin
          state_nxt_s = BOOT;
        end
      end
      LOAD: begin
        if (!dl_act) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = LOAD;
        end
      end
      DRAIN: begin
        // wr_stb_r is high exactly when count_r != 0, so this covers pending writes
        if (count_r == 3'd0) begin
          state_nxt_s    = HOLD;
          hold_cnt_nxt_s = HOLD_CYC;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      HOLD: begin
        if (dl_act) begin
          state_nxt_s = LOAD;
        end else if (hold_cnt_r <= 8'd1) begin
          state_nxt_s = RUN;
        end else begin
          hold_cnt_nxt_s = hold_cnt_r - 8'd1;
        end
      end
      RUN: begin
        if (dl_act) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = BOOT;
      end
    endcase
  end

  // Session status next values; entering LOAD starts a fresh session.
  always_comb begin
    enter_load_s   = (state_nxt_s == LOAD) && (state_r != LOAD);
    dl_ovf_nxt_s   = dl_ovf_r;
    byte_cnt_nxt_s = byte_cnt_r;
    if (enter_load_s) begin
      dl_ovf_nxt_s   = 1'b0;
      byte_cnt_nxt_s = 25'd0;
    end else begin
      if (drop_s) begin
        dl_ovf_nxt_s = 1'b1;
      end else begin
        dl_ovf_nxt_s = dl_ovf_r;
      end
      if (accept_s && (byte_cnt_r != CNT_MAX)) begin
        byte_cnt_nxt_s = byte_cnt_r + 25'd1;
      end else begin
        byte_cnt_nxt_s = byte_cnt_r;
      end
    end
  end

  // Control, FIFO pointer and output registers.
  always_ff @(posedge clk48M) begin
    if (reset) begin
      state_r     <= BOOT;
      hold_cnt_r  <= 8'd0;
      rd_ptr_r    <= 2'd0;
      wr_ptr_r    <= 2'd0;
      count_r     <= 3'd0;
      wr_stb_r    <= 1'b0;
      wr_sel_r    <= 4'b0000;
      wr_addr_r   <= 16'd0;
      wr_data_r   <= 8'd0;
      sys_reset_r <= 1'b1;
      dl_ovf_r    <= 1'b0;
      byte_cnt_r  <= 25'd0;
    end else begin
      state_r     <= state_nxt_s;
      hold_cnt_r  <= hold_cnt_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      wr_ptr_r    <= wr_ptr_nxt_s;
      count_r     <= count_nxt_s;
      wr_stb_r    <= (count_nxt_s != 3'd0);
      wr_sel_r    <= (count_nxt_s != 3'd0) ? head_nxt_s.sel  : 4'b0000;
      wr_addr_r   <= (count_nxt_s != 3'd0) ? head_nxt_s.addr : 16'd0;
      wr_data_r   <= (count_nxt_s != 3'd0) ? head_nxt_s.data : 8'd0;
      sys_reset_r <= (state_nxt_s != RUN);
      dl_ovf_r    <= dl_ovf_nxt_s;
      byte_cnt_r  <= byte_cnt_nxt_s;
    end
  end

  // FIFO storage; contents need no reset because the pointers are flushed.
  always_ff @(posedge clk48M) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_s;
    end
  end

  // dl_done rises with the RUN entry and falls only when a new session starts.
  always_ff @(posedge clk48M) begin
    if (reset) begin
      dl_done_r <= dl_done_r;
    end else if (enter_load_s) begin
      dl_done_r <= 1'b0;
    end else if (state_nxt_s == RUN) begin
      dl_done_r <= 1'b1;
    end
  end

  assign wr.wr_stb  = wr_stb_r;
  assign wr.wr_sel  = wr_sel_r;
  assign wr.wr_addr = wr_addr_r;
  assign wr.wr_data = wr_data_r;
  assign sys_reset  = sys_reset_r;
  assign dl_done    = dl_done_r;
  assign dl_ovf     = dl_ovf_r;
  assign byte_cnt   = byte_cnt_r;

endmodule

// File: tb/tb_segasys1_romload_ctrl.sv
// ----------------------------------------------------------------------------
// tb_segasys1_romload_ctrl
// Directed sessions with randomized addresses/data. A queue-based reference
// model (region table, 4-deep write queue, session counters) predicts every
// write port cycle plus byte_cnt / dl_ovf, and the sys_reset/dl_done timing.
// ----------------------------------------------------------------------------
module tb_segasys1_romload_ctrl;

  localparam int HOLD_CYC = 16;
  localparam logic [24:0] BOUND  [5] = '{25'h0, 25'h0C000, 25'h0E000, 25'h1A000, 25'h2A000};
  localparam logic [24:0] RSTART [5] = '{25'h0, 25'h0BFF0, 25'h0DFF0, 25'h19FF0, 25'h29FE0};

  typedef struct packed {
    logic [3:0]  sel;
    logic [15:0] addr;
    logic [7:0]  data;
  } ent_t;

  logic        clk48M = 1'b0;
  logic        reset, dl_act, ROMEN;
  logic [24:0] ROMAD;
  logic [7:0]  ROMDT;
  logic        sys_reset, dl_done, dl_ovf;
  logic [24:0] byte_cnt;

  segasys1_romload_ctrl_if wr_if();

  segasys1_romload_ctrl dut (
    .clk48M    (clk48M),
    .reset     (reset),
    .dl_act    (dl_act),
    .ROMEN     (ROMEN),
    .ROMAD     (ROMAD),
    .ROMDT     (ROMDT),
    .wr        (wr_if),
    .sys_reset (sys_reset),
    .dl_done   (dl_done),
    .dl_ovf    (dl_ovf),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk48M = ~clk48M;

  ent_t fifo_q[$];
  logic m_load = 1'b0;
  logic m_ovf  = 1'b0;
  int   m_cnt  = 0;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_wr = 0;
  int   cyc_no = 0;
  int   last_wr_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_decode(input logic [24:0] ad, input logic [7:0] dt,
                                     output logic hit, output ent_t e);
    logic [24:0] off;
    hit = 1'b0;
    e   = '0;
    for (int r = 0; r < 4; r++) begin
      if (ad >= BOUND[r] && ad < BOUND[r+1]) begin
        hit    = 1'b1;
        off    = ad - BOUND[r];
        e.sel  = 4'b0001 << r;
        e.addr = off[15:0];
        e.data = dt;
      end
    end
  endfunction

  // One clock cycle: check the presented write against the model, apply inputs,
  // advance the model, then step to 1 time unit after the next rising edge.
  task automatic cyc(input logic en, input logic [24:0] ad, input logic [7:0] dt, input logic rdy);
    ent_t e;
    logic hit;
    ROMEN = en; ROMAD = ad; ROMDT = dt; wr_if.wr_rdy = rdy;
    if (fifo_q.size() > 0) begin
      chk("wr_stb",  {31'd0, wr_if.wr_stb}, 32'd1);
      chk("wr_sel",  {28'd0, wr_if.wr_sel},  {28'd0, fifo_q[0].sel});
      chk("wr_addr", {16'd0, wr_if.wr_addr}, {16'd0, fifo_q[0].addr});
      chk("wr_data", {24'd0, wr_if.wr_data}, {24'd0, fifo_q[0].data});
      if (rdy) begin
        void'(fifo_q.pop_front());
        n_wr++;
        last_wr_cyc = cyc_no;
      end
    end else begin
      chk("wr_stb_idle", {31'd0, wr_if.wr_stb}, 32'd0);
      chk("wr_sel_idle", {28'd0, wr_if.wr_sel}, 32'd0);
    end
    if (m_load && en) begin
      m_cnt++;
      ref_decode(ad, dt, hit, e);
      if (hit) begin
        if (fifo_q.size() < 4) fifo_q.push_back(e);
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk48M); #1;
    cyc_no++;
  endtask

  task automatic start_load();
    dl_act = 1'b1;
    cyc(1'b0, 25'd0, 8'd0, 1'b1);
    m_load = 1'b1; m_cnt = 0; m_ovf = 1'b0;
    chk("load_sysrst",   {31'd0, sys_reset}, 32'd1);
    chk("load_done_clr", {31'd0, dl_done},   32'd0);
    chk("load_cnt_clr",  {7'd0, byte_cnt},   32'd0);
    chk("load_ovf_clr",  {31'd0, dl_ovf},    32'd0);
  endtask

  task automatic end_load(input logic rdy);
    dl_act = 1'b0;
    cyc(1'b0, 25'd0, 8'd0, rdy);
    m_load = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (fifo_q.size() > 0 && k < 50) begin
      cyc(1'b0, 25'd0, 8'd0, 1'b1);
      k++;
    end
    chk("drain_bound", fifo_q.size(), 32'd0);
    repeat (3) cyc(1'b0, 25'd0, 8'd0, 1'b1);
  endtask

  initial begin
    logic [24:0] ad;
    logic [7:0]  dt;
    int          n_wr0, n_hit, k;
    ent_t        e;
    logic        hit;

    reset = 1'b1; dl_act = 1'b0; ROMEN = 1'b0; ROMAD = 25'd0; ROMDT = 8'd0;
    wr_if.wr_rdy = 1'b1;
    @(posedge clk48M); #1;
    chk("rst_stb",    {31'd0, wr_if.wr_stb}, 32'd0);
    chk("rst_sel",    {28'd0, wr_if.wr_sel}, 32'd0);
    chk("rst_addr",   {16'd0, wr_if.wr_addr}, 32'd0);
    chk("rst_data",   {24'd0, wr_if.wr_data}, 32'd0);
    chk("rst_sysrst", {31'd0, sys_reset}, 32'd1);
    chk("rst_ovf",    {31'd0, dl_ovf}, 32'd0);
    chk("rst_cnt",    {7'd0, byte_cnt}, 32'd0);
    chk("rst_done",   {31'd0, dl_done}, 32'd0);
    reset = 1'b0;
    repeat (4) cyc(1'b0, 25'd0, 8'd0, 1'b1);
    chk("boot_sysrst", {31'd0, sys_reset}, 32'd1);

    // Session A: random bytes, region boundary sweeps, wr_rdy tied high.
    start_load();
    n_wr0 = n_wr; n_hit = 0;
    for (int i = 0; i < 64; i++) begin
      ad = 25'($urandom_range(0, 32'h2A00F));
      ref_decode(ad, ad[7:0], hit, e);
      if (hit) n_hit++;
      cyc(1'b1, ad, ad[7:0], 1'b1);
    end
    cyc(1'b1, 25'h0E005, 8'h05, 1'b1);
    n_hit++;
    chk("ex_sel",  {28'd0, wr_if.wr_sel},  32'h4);
    chk("ex_addr", {16'd0, wr_if.wr_addr}, 32'h5);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 32; i++) begin
        ad = RSTART[r] + 25'(i);
        n_hit++;
        cyc(1'b1, ad, ad[7:0], 1'b1);
      end
    end
    end_load(1'b1);
    chk("a_writes", n_wr - n_wr0, n_hit);
    chk("a_cnt",    {7'd0, byte_cnt}, m_cnt);
    chk("a_cnt_n",  {7'd0, byte_cnt}, 32'd225);
    chk("a_ovf",    {31'd0, dl_ovf}, 32'd0);
    // DRAIN needs one cycle to see the queue empty, then HOLD_CYC hold cycles.
    k = 0;
    while (sys_reset === 1'b1 && k < 200) begin
      chk("hold_done_low", {31'd0, dl_done}, 32'd0);
      cyc(1'b0, 25'd0, 8'd0, 1'b1);
      k++;
    end
    chk("fall_delay", cyc_no - last_wr_cyc, HOLD_CYC + 2);
    chk("run_done",   {31'd0, dl_done}, 32'd1);

    // Session B: overflow with the target stalled.
    start_load();
    for (int i = 0; i < 6; i++) begin
      ad = 25'($urandom_range(0, 32'h29FFF));
      cyc(1'b1, ad, 8'($urandom), 1'b0);
    end
    chk("ovf_set",   {31'd0, dl_ovf}, 32'd1);
    chk("ovf_model", {31'd0, dl_ovf}, {31'd0, m_ovf});
    chk("ovf_cnt",   {7'd0, byte_cnt}, 32'd6);
    n_wr0 = n_wr;
    end_load(1'b0);
    drain();
    chk("ovf_writes", n_wr - n_wr0, 32'd4);

    // Session C: 100-byte burst with wr_rdy toggling every cycle.
    start_load();
    n_wr0 = n_wr;
    for (int i = 0; i < 200; i++) begin
      ad = 25'($urandom_range(0, 32'h29FFF));
      dt = 8'($urandom);
      cyc((i % 2) == 0, ad, dt, (i % 2) == 0);
    end
    end_load(1'b1);
    drain();
    chk("tog_writes", n_wr - n_wr0, 32'd100);
    chk("tog_ovf",    {31'd0, dl_ovf}, 32'd0);

    // Session D: bytes beyond the sprite ROM are counted but never written.
    start_load();
    n_wr0 = n_wr;
    for (int i = 0; i < 16; i++) cyc(1'b1, 25'h2A000 + 25'(i), 8'(i), 1'b1);
    cyc(1'b0, 25'd0, 8'd0, 1'b1);
    chk("disc_cnt",    {7'd0, byte_cnt}, 32'd16);
    chk("disc_writes", n_wr - n_wr0, 32'd0);
    end_load(1'b1);
    drain();

    // Session E: reset mid-LOAD with 3 entries queued, dl_act kept high.
    start_load();
    for (int i = 0; i < 3; i++) cyc(1'b1, 25'($urandom_range(0, 32'h29FFF)), 8'($urandom), 1'b0);
    ROMEN = 1'b0; reset = 1'b1;
    @(posedge clk48M); #1;
    cyc_no++;
    chk("mrst_stb",    {31'd0, wr_if.wr_stb}, 32'd0);
    chk("mrst_sel",    {28'd0, wr_if.wr_sel}, 32'd0);
    chk("mrst_sysrst", {31'd0, sys_reset}, 32'd1);
    chk("mrst_cnt",    {7'd0, byte_cnt}, 32'd0);
    fifo_q.delete(); m_load = 1'b0; reset = 1'b0;
    cyc(1'b0, 25'd0, 8'd0, 1'b1);
    m_load = 1'b1; m_cnt = 0; m_ovf = 1'b0;
    n_wr0 = n_wr;
    cyc(1'b1, 25'h0C010, 8'hA5, 1'b1);
    cyc(1'b1, 25'h1A020, 8'h5A, 1'b1);
    chk("mrst_reload_cnt", {7'd0, byte_cnt}, 32'd2);
    end_load(1'b1);
    drain();
    chk("mrst_writes", n_wr - n_wr0, 32'd2);
    k = 0;
    while (sys_reset === 1'b1 && k < 100) begin
      cyc(1'b0, 25'd0, 8'd0, 1'b1);
      k++;
    end
    chk("e_run", {31'd0, sys_reset}, 32'd0);
    chk("e_done", {31'd0, dl_done}, 32'd1);

    // Reset in RUN: back to RUN after HOLD_CYC+1 cycles with no download.
    reset = 1'b1;
    @(posedge clk48M); #1;
    cyc_no++;
    reset = 1'b0;
    chk("rrun_sysrst", {31'd0, sys_reset}, 32'd1);
    k = 0;
    while (sys_reset === 1'b1 && k < 100) begin
      chk("rrun_done", {31'd0, dl_done}, 32'd1);
      cyc(1'b0, 25'd0, 8'd0, 1'b1);
      k++;
    end
    chk("rrun_cycles", k, HOLD_CYC + 1);
    chk("rrun_done_end", {31'd0, dl_done}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
